writeback_arbiter: RTL and testbench

- Writer-side front end for the CPU register file.
- Collects result writes from the ALU path and the load/memory path over valid/ready handshakes and buffers them in a small FIFO.
- Drains the FIFO one entry per cycle onto the register file's single write port: rf_data, rf_we, rf_rd feed the regfile's data, we and rd inputs.
- Keeps a busy scoreboard of destination registers with results still in flight, for the hazard logic.

---
 rtl/writeback_arbiter.sv | 141 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback front end: merges ALU and load results into a small FIFO, drains one
// entry per cycle onto the register-file write port and tracks pending destinations.
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alu_valid,
    input  logic [ADDR_WIDTH-1:0]              alu_rd,
    input  logic [DATA_WIDTH-1:0]              alu_data,
    output logic                               alu_ready,
    input  logic                               mem_valid,
    input  logic [ADDR_WIDTH-1:0]              mem_rd,
    input  logic [DATA_WIDTH-1:0]              mem_data,
    output logic                               mem_ready,
    input  logic                               issue_valid,
    input  logic [ADDR_WIDTH-1:0]              issue_rd,
    output logic                               rf_we,
    output logic [ADDR_WIDTH-1:0]              rf_rd,
    output logic [DATA_WIDTH-1:0]              rf_data,
    output logic [(1<<ADDR_WIDTH)-1:0]         busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int NREG  = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_rf_we;
    logic [ADDR_WIDTH-1:0] r_rf_rd;
    logic [DATA_WIDTH-1:0] r_rf_data;
    logic [NREG-1:0]       r_busy;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_mem;
    logic                  w_push_alu;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_push_rd;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [ADDR_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_live;
    logic [NREG-1:0]       w_busy_nxt;

    // Fullness is taken from registered occupancy, so a same-cycle pop never frees a slot.
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);

    assign mem_ready = !w_full;
    assign alu_ready = !w_full && !mem_valid;

    assign w_push_mem  = mem_valid && !w_full;
    assign w_push_alu  = alu_valid && alu_ready;
    assign w_push      = w_push_mem || w_push_alu;
    assign w_push_rd   = w_push_mem ? mem_rd   : alu_rd;
    assign w_push_data = w_push_mem ? mem_data : alu_data;

    assign w_pop       = !w_empty;
    assign w_head_rd   = r_rd_mem[r_rptr];
    assign w_head_data = r_data_mem[r_rptr];
    assign w_head_live = (w_head_rd != '0);

    // Buffer storage carries no reset; occupancy alone says which slots are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wptr]   <= w_push_rd;
            r_data_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write port: an entry targeting x0 still drains but never asserts the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we <= w_pop && w_head_live;
            if (w_pop) begin
                r_rf_rd   <= w_head_rd;
                r_rf_data <= w_head_data;
            end
        end
    end

    // Clear on drain first, then set on issue, so a same-edge issue keeps the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop && w_head_live) begin
            w_busy_nxt[w_head_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign rf_we      = r_rf_we;
    assign rf_rd      = r_rf_rd;
    assign rf_data    = r_rf_data;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-based reference model checked every cycle.
module tb_writeback_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid, issue_valid;
    logic [AW-1:0] alu_rd, mem_rd, issue_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic [31:0]   busy;
    logic [2:0]    fifo_count;

    int tests = 0;
    int fails = 0;

    writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model: a plain queue of accepted results plus a pending-register bitmap.
    ent_t        q[$];
    ent_t        m_head;
    logic        m_full, m_pop;
    logic        m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    logic [31:0] m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_we   = 1'b0;
            m_rd   = '0;
            m_data = '0;
            m_busy = '0;
        end else begin
            m_full = (q.size() >= DEPTH);
            m_pop  = (q.size() != 0);
            if (m_pop) m_head = q.pop_front();
            if (mem_valid && !m_full) q.push_back('{mem_rd, mem_data});
            else if (alu_valid && !m_full) q.push_back('{alu_rd, alu_data});
            if (m_pop) begin
                m_we   = (m_head.rd != 0);
                m_rd   = m_head.rd;
                m_data = m_head.data;
                if (m_head.rd != 0) m_busy[m_head.rd] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    ent_t wlog[$];
    int   max_count = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rf_we",      64'(rf_we),      64'(m_we));
            chk("rf_rd",      64'(rf_rd),      64'(m_rd));
            chk("rf_data",    64'(rf_data),    64'(m_data));
            chk("busy",       64'(busy),       64'(m_busy));
            chk("fifo_count", 64'(fifo_count), 64'(q.size()));
            chk("mem_ready",  64'(mem_ready),  64'(q.size() < DEPTH));
            chk("alu_ready",  64'(alu_ready),  64'((q.size() < DEPTH) && !mem_valid));
            if (rf_we) wlog.push_back('{rf_rd, rf_data});
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        issue_valid = 0; issue_rd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("reset_we",    64'(rf_we), 64'h0);
        chk("reset_rd",    64'(rf_rd), 64'h0);
        chk("reset_data",  64'(rf_data), 64'h0);
        chk("reset_busy",  64'(busy), 64'h0);
        chk("reset_count", 64'(fifo_count), 64'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 chk("single_alu_ready", 64'(alu_ready), 64'h1);
        tick();
        idle_inputs();
        chk("single_count", 64'(fifo_count), 64'h1);
        chk("single_we_pre", 64'(rf_we), 64'h0);
        tick();
        chk("single_we",   64'(rf_we), 64'h1);
        chk("single_rd",   64'(rf_rd), 64'h5);
        chk("single_data", 64'(rf_data), 64'hDEADBEEF);
        tick();
        chk("single_we_once", 64'(rf_we), 64'h0);

        // Memory priority over ALU
        mem_valid = 1; mem_rd = 3; mem_data = 32'h11;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
        #1;
        chk("prio_mem_ready", 64'(mem_ready), 64'h1);
        chk("prio_alu_ready", 64'(alu_ready), 64'h0);
        tick();
        mem_valid = 0;
        #1 chk("prio_alu_ready2", 64'(alu_ready), 64'h1);
        tick();
        alu_valid = 0;
        chk("prio_first_rd",   64'(rf_rd), 64'h3);
        chk("prio_first_data", 64'(rf_data), 64'h11);
        tick();
        chk("prio_second_we",   64'(rf_we), 64'h1);
        chk("prio_second_rd",   64'(rf_rd), 64'h4);
        chk("prio_second_data", 64'(rf_data), 64'h22);
        tick();

        // Back-to-back load results
        wlog.delete();
        max_count = 0;
        for (int i = 1; i <= 5; i++) begin
            mem_valid = 1; mem_rd = AW'(i); mem_data = 32'h100 + i;
            waited = 0;
            #1;
            while (!mem_ready && waited < 20) begin
                tick();
                waited++;
            end
            if (waited >= 20) chk("bp_accept_timeout", 64'h0, 64'h1);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        repeat (4) tick();
        chk("bp_write_count", 64'(wlog.size()), 64'h5);
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            chk("bp_order_rd",   64'(wlog[i].rd),   64'(i + 1));
            chk("bp_order_data", 64'(wlog[i].data), 64'(32'h101 + i));
        end
        chk("bp_max_count", 64'(max_count), 64'h1);

        // Register zero
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
        issue_valid = 1; issue_rd = 0;
        tick();
        idle_inputs();
        chk("x0_count", 64'(fifo_count), 64'h1);
        chk("x0_busy",  64'(busy), 64'h0);
        tick();
        chk("x0_we",    64'(rf_we), 64'h0);
        chk("x0_data",  64'(rf_data), 64'hFFFFFFFF);
        chk("x0_drain", 64'(fifo_count), 64'h0);
        tick();

        // Scoreboard set/clear race
        issue_valid = 1; issue_rd = 7;
        tick();
        chk("race_busy_set", 64'(busy[7]), 64'h1);
        issue_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        tick();
        alu_valid = 0;
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        chk("race_pop_we",   64'(rf_we), 64'h1);
        chk("race_busy_hold", 64'(busy[7]), 64'h1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
        tick();
        alu_valid = 0;
        tick();
        chk("race_busy_clear", 64'(busy[7]), 64'h0);
        chk("race_second_data", 64'(rf_data), 64'h78);

        // Asynchronous reset with an entry in flight
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        issue_valid = 1; issue_rd = 9;
        tick();
        idle_inputs();
        chk("ar_pre_count", 64'(fifo_count), 64'h1);
        chk("ar_pre_busy",  64'(busy[9]), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("ar_count", 64'(fifo_count), 64'h0);
        chk("ar_busy",  64'(busy), 64'h0);
        chk("ar_we",    64'(rf_we), 64'h0);
        chk("ar_rd",    64'(rf_rd), 64'h0);
        chk("ar_data",  64'(rf_data), 64'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ar_idle_we",    64'(rf_we), 64'h0);
            chk("ar_idle_busy",  64'(busy), 64'h0);
            chk("ar_idle_count", 64'(fifo_count), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
